// File: rtl/genetic_pkg.sv
// genetic_pkg: shared genetic-core geometry (ROW, COL, OUT, IN, BITS_ELEM, BITS_MAT, CHROM_W) and the loader_state_t enum
package genetic_pkg;
    localparam int ROW       = 2;
    localparam int COL       = 1;
    localparam int OUT       = 1;
    localparam int IN        = 4;
    localparam int BITS_ELEM = 2;
    localparam int BITS_MAT  = ROW * COL * 16;
    localparam int CHROM_W   = BITS_MAT + BITS_ELEM * OUT;
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} loader_state_t;
endpackage

// File: rtl/chrom_serial_loader.sv
// chrom_serial_loader: LSB-first serial chromosome loader with trailing even parity; in clk/reset/start/bit_valid/bit_in, out busy/chrom/chrom_update/parity_err/load_count
module chrom_serial_loader
    import genetic_pkg::*;
#(
    parameter logic [CHROM_W-1:0] INIT_CHROM = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               bit_valid,
    input  logic               bit_in,
    output logic               busy,
    output logic [CHROM_W-1:0] chrom,
    output logic               chrom_update,
    output logic               parity_err,
    output logic [7:0]         load_count
);
    localparam int CNT_W = $clog2(CHROM_W);
    loader_state_t      state_q, state_d;
    logic [CHROM_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               acc_q, acc_d, commit, err;
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        commit   = 1'b0;
        err      = 1'b0;
        if (start) begin
            state_d = SHIFT;
            cnt_d   = '0;
            acc_d   = 1'b0;
        end else if (bit_valid) begin
            case (state_q)
                SHIFT: begin
                    shadow_d[cnt_q] = bit_in;
                    acc_d           = acc_q ^ bit_in;
                    cnt_d           = cnt_q + 1'b1;
                    state_d         = cnt_q == CNT_W'(CHROM_W - 1) ? PARITY : SHIFT;
                end
                PARITY: begin
                    state_d = IDLE;
                    commit  = ~(acc_q ^ bit_in);
                    err     = acc_q ^ bit_in;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            cnt_q        <= '0;
            acc_q        <= 1'b0;
            chrom        <= INIT_CHROM;
            chrom_update <= 1'b0;
            parity_err   <= 1'b0;
            load_count   <= '0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            chrom        <= commit ? shadow_q : chrom;
            chrom_update <= commit;
            parity_err   <= err;
            load_count   <= load_count + {7'd0, commit};
        end
    end
    assign busy = state_q != IDLE;
endmodule

// File: tb/tb_chrom_serial_loader.sv
// tb_chrom_serial_loader: table-driven, hand-written and randomized checks of chrom_serial_loader against a frame-level model
module tb_chrom_serial_loader;
    import genetic_pkg::*;
    logic               clk = 0, reset = 0, start = 0, bit_valid = 0, bit_in = 0;
    logic               busy, chrom_update, parity_err;
    logic [CHROM_W-1:0] chrom;
    logic [7:0]         load_count;
    int n_cmp = 0, n_bad = 0, n_upd = 0;
    logic [CHROM_W-1:0] m_chrom;
    logic [7:0]         m_count;

    chrom_serial_loader dut (
        .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
        .busy(busy), .chrom(chrom), .chrom_update(chrom_update), .parity_err(parity_err),
        .load_count(load_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               rst_before;
        logic [CHROM_W-1:0] data;
        logic               par;
        logic [CHROM_W-1:0] exp_chrom;
        logic [7:0]         exp_count;
        logic               exp_upd;
        logic               exp_err;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (chrom_update) n_upd++;
        check("exclusive", {63'd0, chrom_update & parity_err}, 64'd0);
    endtask

    task automatic do_reset();
        reset = 1; start = 0; bit_valid = 0;
        tick();
        reset = 0;
        m_chrom = '0;
        m_count = '0;
    endtask

    task automatic pulse_start();
        start = 1; bit_valid = 0;
        tick();
        start = 0;
    endtask

    task automatic send_bit(input logic b, input int max_gap);
        repeat ($urandom_range(0, max_gap)) begin
            bit_valid = 0;
            bit_in = 1'($urandom);
            tick();
        end
        bit_valid = 1;
        bit_in = b;
        tick();
        bit_valid = 0;
    endtask

    task automatic send_bits(input logic [CHROM_W-1:0] d, input logic p, input int max_gap);
        for (int i = 0; i < CHROM_W; i++) send_bit(d[i], max_gap);
        send_bit(p, max_gap);
    endtask

    task automatic stray_idle(input int n);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1;
            bit_in = 1'($urandom);
            tick();
        end
        bit_valid = 0;
    endtask

    task automatic check_frame(input string tag, input logic [CHROM_W-1:0] d, input logic p);
        logic good;
        good = ~^{d, p};
        if (good) begin
            m_chrom = d;
            m_count = m_count + 8'd1;
        end
        check({tag, " chrom"}, 64'(chrom), 64'(m_chrom));
        check({tag, " count"}, 64'(load_count), 64'(m_count));
        check({tag, " upd"}, 64'(chrom_update), 64'(good));
        check({tag, " err"}, 64'(parity_err), 64'(!good));
        check({tag, " busy"}, 64'(busy), 64'd0);
        tick();
        check({tag, " upd_off"}, 64'(chrom_update), 64'd0);
        check({tag, " err_off"}, 64'(parity_err), 64'd0);
    endtask

    initial begin
        int upd0;
        logic [CHROM_W-1:0] d;
        logic p;
        vecs[0] = '{1'b1, 34'h2_0100_1000, 1'b1, 34'h2_0100_1000, 8'd1, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 34'h2_0100_1000, 1'b0, 34'h0,           8'd0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 34'h3_FFFF_0000, 1'b0, 34'h3_FFFF_0000, 8'd1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 34'h0_0000_0001, 1'b0, 34'h3_FFFF_0000, 8'd1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 34'h0_0000_0001, 1'b1, 34'h0_0000_0001, 8'd2, 1'b1, 1'b0};

        do_reset();
        check("rst chrom", 64'(chrom), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst count", 64'(load_count), 64'd0);
        check("rst upd", 64'(chrom_update), 64'd0);
        check("rst err", 64'(parity_err), 64'd0);

        foreach (vecs[k]) begin
            if (vecs[k].rst_before) do_reset();
            pulse_start();
            check($sformatf("vec%0d busy", k), 64'(busy), 64'd1);
            send_bits(vecs[k].data, vecs[k].par, 0);
            check($sformatf("vec%0d chrom", k), 64'(chrom), 64'(vecs[k].exp_chrom));
            check($sformatf("vec%0d count", k), 64'(load_count), 64'(vecs[k].exp_count));
            check($sformatf("vec%0d upd", k), 64'(chrom_update), 64'(vecs[k].exp_upd));
            check($sformatf("vec%0d err", k), 64'(parity_err), 64'(vecs[k].exp_err));
            check($sformatf("vec%0d busy_off", k), 64'(busy), 64'd0);
            tick();
            check($sformatf("vec%0d pulse_len", k), 64'(chrom_update | parity_err), 64'd0);
        end

        do_reset();
        upd0 = n_upd;
        pulse_start();
        for (int i = 0; i < 10; i++) send_bit(1'b1, 0);
        pulse_start();
        send_bits(34'h3_FFFF_0000, 1'b0, 0);
        check("abort chrom", 64'(chrom), 64'h3_FFFF_0000);
        tick();
        check("abort one_pulse", 64'(n_upd - upd0), 64'd1);
        check("abort count", 64'(load_count), 64'd1);

        do_reset();
        stray_idle(5);
        check("stray busy", 64'(busy), 64'd0);
        pulse_start();
        send_bits(34'h2_0100_1000, 1'b1, 5);
        check("gap chrom", 64'(chrom), 64'h2_0100_1000);
        stray_idle(4);
        check("stray chrom", 64'(chrom), 64'h2_0100_1000);
        check("stray count", 64'(load_count), 64'd1);

        pulse_start();
        for (int i = 0; i < 20; i++) send_bit(1'b1, 0);
        do_reset();
        check("midrst chrom", 64'(chrom), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        pulse_start();
        send_bits(34'h0_0000_0001, 1'b1, 0);
        check("midrst frame", 64'(chrom), 64'h1);
        check("midrst count", 64'(load_count), 64'd1);
        m_chrom = 34'h1;
        m_count = 8'd1;
        tick();

        for (int it = 0; it < 40; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                pulse_start();
                for (int i = 0; i < $urandom_range(1, 33); i++) send_bit(1'($urandom), 2);
                do_reset();
                check("rnd rst chrom", 64'(chrom), 64'd0);
            end else if (r == 1) begin
                pulse_start();
                for (int i = 0; i < $urandom_range(1, 34); i++) send_bit(1'($urandom), 2);
            end
            stray_idle($urandom_range(0, 3));
            d = {2'($urandom), 32'($urandom)};
            p = ^d ^ ($urandom_range(0, 3) == 0);
            pulse_start();
            send_bits(d, p, 3);
            check_frame("rnd", d, p);
        end

        start = 1; bit_valid = 1; bit_in = 1;
        tick();
        start = 0;
        send_bits('0, 1'b0, 0);
        check_frame("coincident", '0, 1'b0);
        check("coincident chrom0", 64'(chrom), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
